// File: rtl/pattern_pkg.sv
// Shared encodings, bar colour table and FSM state type for the test-pattern writer.
package pattern_pkg;

    localparam logic [1:0] MODE_BARS  = 2'd0;
    localparam logic [1:0] MODE_SOLID = 2'd1;
    localparam logic [1:0] MODE_CHECK = 2'd2;
    localparam logic [1:0] MODE_GRAD  = 2'd3;

    localparam logic [23:0] BAR_C0 = 24'hC0C0C0;
    localparam logic [23:0] BAR_C1 = 24'hC0C000;
    localparam logic [23:0] BAR_C2 = 24'h00C0C0;
    localparam logic [23:0] BAR_C3 = 24'h00C000;
    localparam logic [23:0] BAR_C4 = 24'hC000C0;
    localparam logic [23:0] BAR_C5 = 24'hC00000;
    localparam logic [23:0] BAR_C6 = 24'h0000C0;
    localparam logic [23:0] BAR_C7 = 24'hFFFFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Colour-bar lookup: eight equal-width vertical bars across the frame.
    function automatic logic [23:0] bar_color(input logic [2:0] idx);
        logic [23:0] c;
        case (idx)
            3'd0:    c = BAR_C0;
            3'd1:    c = BAR_C1;
            3'd2:    c = BAR_C2;
            3'd3:    c = BAR_C3;
            3'd4:    c = BAR_C4;
            3'd5:    c = BAR_C5;
            3'd6:    c = BAR_C6;
            default: c = BAR_C7;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/pattern_pixel.sv
// Combinational pixel function: (x, y, mode, colours) -> 24-bit RGB.
module pattern_pixel
    import pattern_pkg::*;
#(
    parameter int unsigned XW   = 5,
    parameter int unsigned YW   = 5,
    parameter int unsigned CELL = 4
) (
    input  logic [XW-1:0] x_i,
    input  logic [YW-1:0] y_i,
    input  logic [1:0]    mode_i,
    input  logic [23:0]   color_a_i,
    input  logic [23:0]   color_b_i,
    output logic [23:0]   pixel_o
);

    localparam int unsigned CW = $clog2(CELL);

    logic [7:0]    grad;
    logic [XW-1:0] x_cell;
    logic [YW-1:0] y_cell;

    // Gradient ramp: the top eight bits of x, or x left-justified into 8 bits for narrow frames.
    if (XW >= 8) begin : g_grad_wide
        assign grad = x_i[XW-1 -: 8];
    end else begin : g_grad_narrow
        assign grad = 8'(x_i) << (8 - XW);
    end

    // Cell coordinates; a shift past the coordinate width correctly yields zero.
    assign x_cell = x_i >> CW;
    assign y_cell = y_i >> CW;

    // Pattern select.
    always_comb begin
        pixel_o = 24'h000000;
        case (mode_i)
            MODE_BARS:  pixel_o = bar_color(x_i[XW-1 -: 3]);
            MODE_SOLID: pixel_o = color_a_i;
            MODE_CHECK: pixel_o = (x_cell[0] ^ y_cell[0]) ? color_b_i : color_a_i;
            default:    pixel_o = {grad, grad, grad};
        endcase
    end

endmodule

// File: rtl/test_pattern_writer.sv
// Frame-buffer test-pattern generator: writes one IMG_W x IMG_H frame into SRAM per start.
module test_pattern_writer
    import pattern_pkg::*;
#(
    parameter int unsigned IMG_W  = 32,
    parameter int unsigned IMG_H  = 32,
    parameter int unsigned ADDR_W = 18,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CELL   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [23:0]       color_a,
    input  logic [23:0]       color_b,
    input  logic              wr_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done
);

    localparam int unsigned XW = $clog2(IMG_W);
    localparam int unsigned YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [XW-1:0] X_MAX = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(IMG_H - 1);

    state_e            state_q, state_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        mode_q, mode_d;
    logic [23:0]       ca_q, ca_d;
    logic [23:0]       cb_q, cb_d;
    logic [23:0]       data_q, data_d;
    logic              wr_en_q, wr_en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              load_pix;
    logic              xfer;
    logic              last_pix;
    logic [23:0]       pix;

    assign xfer     = wr_en_q & wr_ready;
    assign last_pix = (x_q == X_MAX) && (y_q == Y_MAX);

    // Pixel is evaluated on the next coordinate so the registered data never lags the address.
    pattern_pixel #(
        .XW   (XW),
        .YW   (YW),
        .CELL (CELL)
    ) u_pixel (
        .x_i       (x_d),
        .y_i       (y_d),
        .mode_i    (mode_d),
        .color_a_i (ca_d),
        .color_b_i (cb_d),
        .pixel_o   (pix)
    );

    // Next-state, raster counters, address accumulator and handshake control.
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        addr_d   = addr_q;
        mode_d   = mode_q;
        ca_d     = ca_q;
        cb_d     = cb_q;
        wr_en_d  = wr_en_q;
        busy_d   = busy_q;
        done_d   = done_q;
        load_pix = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d  = ST_WRITE;
                    x_d      = '0;
                    y_d      = '0;
                    addr_d   = base_addr;
                    mode_d   = mode;
                    ca_d     = color_a;
                    cb_d     = color_b;
                    wr_en_d  = 1'b1;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    load_pix = 1'b1;
                end
            end
            ST_WRITE: begin
                if (xfer) begin
                    if (last_pix) begin
                        state_d = ST_DONE;
                        wr_en_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        load_pix = 1'b1;
                        addr_d   = addr_q + ADDR_W'(1);
                        if (x_q == X_MAX) begin
                            x_d = '0;
                            y_d = y_q + YW'(1);
                        end else begin
                            x_d = x_q + XW'(1);
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                wr_en_d = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    // Pixel data register only advances when a new pixel is presented, so it holds during stalls.
    always_comb begin
        data_d = data_q;
        if (load_pix) begin
            data_d = pix;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            addr_q  <= '0;
            mode_q  <= MODE_BARS;
            ca_q    <= '0;
            cb_q    <= '0;
            data_q  <= '0;
            wr_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            addr_q  <= addr_d;
            mode_q  <= mode_d;
            ca_q    <= ca_d;
            cb_q    <= cb_d;
            data_q  <= data_d;
            wr_en_q <= wr_en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = addr_q;
    assign wr_data = DATA_W'(data_q);
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_test_pattern_writer.sv
// Self-checking bench for test_pattern_writer: scoreboard per frame plus spot-value table.
module tb_test_pattern_writer;

    localparam int unsigned IMG_W  = 32;
    localparam int unsigned IMG_H  = 32;
    localparam int unsigned ADDR_W = 18;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CELL   = 4;
    localparam int          NPIX   = IMG_W * IMG_H;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [1:0]        mode;
    logic [ADDR_W-1:0] base_addr;
    logic [23:0]       color_a;
    logic [23:0]       color_b;
    logic              wr_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              busy;
    logic              done;

    always #5 clk = ~clk;

    test_pattern_writer #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .CELL   (CELL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mode      (mode),
        .base_addr (base_addr),
        .color_a   (color_a),
        .color_b   (color_b),
        .wr_ready  (wr_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done)
    );

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } exp_t;

    typedef struct {
        logic [1:0]  m;
        int          x;
        int          y;
        logic [31:0] exp;
    } vec_t;

    exp_t              sb[$];
    logic [DATA_W-1:0] cap_data[4][NPIX];
    logic [ADDR_W-1:0] cap_addr[NPIX];
    vec_t              vecs[16];
    int                checks = 0;
    int                passed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference pixel, written from the pattern definitions rather than from the RTL structure.
    function automatic logic [23:0] model(input logic [1:0] m, input int x, input int y,
                                          input logic [23:0] a, input logic [23:0] b);
        logic [23:0] bars[8];
        bars = '{24'hC0C0C0, 24'hC0C000, 24'h00C0C0, 24'h00C000,
                 24'hC000C0, 24'hC00000, 24'h0000C0, 24'hFFFFFF};
        case (m)
            2'd0:    return bars[x / (IMG_W / 8)];
            2'd1:    return a;
            2'd2:    return ((((x / CELL) ^ (y / CELL)) % 2) == 0) ? a : b;
            default: return {3{8'(x * (256 / IMG_W))}};
        endcase
    endfunction

    // Run one frame (or the first stop_at transfers of it) and score every transfer.
    task automatic run_frame(input logic [1:0] m, input logic [ADDR_W-1:0] b,
                             input logic [23:0] a, input logic [23:0] c,
                             input bit stall, input int stop_at, input int slot);
        int                n;
        int                cyc;
        bit                prev_stall;
        logic [ADDR_W-1:0] pa;
        logic [DATA_W-1:0] pd;
        exp_t              e;
        sb.delete();
        for (int i = 0; i < NPIX; i++) begin
            e.addr = b + ADDR_W'(i);
            e.data = DATA_W'(model(m, i % IMG_W, i / IMG_W, a, c));
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b1; mode = m; base_addr = b; color_a = a; color_b = c; wr_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; mode = ~m; base_addr = ~b; color_a = ~a; color_b = ~c;
        chk("busy_after_start", 64'(busy), 64'd1);
        chk("done_after_start", 64'(done), 64'd0);
        n = 0; cyc = 0; prev_stall = 1'b0; pa = '0; pd = '0;
        while (n < stop_at && cyc < 8 * NPIX) begin
            if (prev_stall) begin
                chk("stall_addr_hold", 64'(wr_addr), 64'(pa));
                chk("stall_data_hold", 64'(wr_data), 64'(pd));
            end
            chk("wr_en_in_frame", 64'(wr_en), 64'd1);
            wr_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            start    = (n == 300);
            if (wr_en && wr_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("wr_addr", 64'(wr_addr), 64'(e.addr));
                    chk("wr_data", 64'(wr_data), 64'(e.data));
                end
                cap_data[slot][n] = wr_data;
                cap_addr[n]       = wr_addr;
                n++;
            end
            prev_stall = wr_en && !wr_ready;
            pa = wr_addr;
            pd = wr_data;
            @(negedge clk);
            cyc++;
        end
        start    = 1'b0;
        wr_ready = 1'b1;
        chk("frame_transfers", 64'(n), 64'(stop_at));
        if (!stall && stop_at == NPIX) chk("frame_cycles", 64'(cyc), 64'(NPIX));
    endtask

    task automatic chk_complete();
        chk("end_wr_en", 64'(wr_en), 64'd0);
        chk("end_busy", 64'(busy), 64'd0);
        chk("end_done", 64'(done), 64'd1);
        chk("sb_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        vecs[0]  = '{2'd0, 0,  0, 32'h00C0C0C0};
        vecs[1]  = '{2'd0, 4,  0, 32'h00C0C000};
        vecs[2]  = '{2'd0, 12, 9, 32'h0000C000};
        vecs[3]  = '{2'd0, 31, 31, 32'h00FFFFFF};
        vecs[4]  = '{2'd1, 0,  0, 32'h00123456};
        vecs[5]  = '{2'd1, 31, 31, 32'h00123456};
        vecs[6]  = '{2'd2, 0,  0, 32'h00FF0000};
        vecs[7]  = '{2'd2, 4,  0, 32'h000000FF};
        vecs[8]  = '{2'd2, 4,  4, 32'h00FF0000};
        vecs[9]  = '{2'd2, 3,  7, 32'h000000FF};
        vecs[10] = '{2'd3, 0,  0, 32'h00000000};
        vecs[11] = '{2'd3, 1,  5, 32'h00080808};
        vecs[12] = '{2'd3, 16, 2, 32'h00808080};
        vecs[13] = '{2'd3, 31, 31, 32'h00F8F8F8};
        vecs[14] = '{2'd2, 8,  8, 32'h00FF0000};
        vecs[15] = '{2'd0, 20, 3, 32'h00C00000};

        reset = 1'b1; start = 1'b0; mode = 2'd0; base_addr = '0;
        color_a = '0; color_b = '0; wr_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_wr_en", 64'(wr_en), 64'd0);
        chk("rst_wr_addr", 64'(wr_addr), 64'd0);
        chk("rst_wr_data", 64'(wr_data), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_no_write", 64'(wr_en), 64'd0);

        // Bars, no back-pressure.
        run_frame(2'd0, 18'h00100, 24'h0, 24'h0, 1'b0, NPIX, 0);
        chk_complete();
        chk("bars_first_addr", 64'(cap_addr[0]), 64'h100);
        chk("bars_last_addr", 64'(cap_addr[NPIX-1]), 64'h4FF);
        repeat (3) @(negedge clk);
        chk("done_held", 64'(done), 64'd1);

        // Solid with random stalls.
        run_frame(2'd1, 18'h02000, 24'h123456, 24'h654321, 1'b1, NPIX, 1);
        chk_complete();

        // Checker with base near the top of the address space.
        run_frame(2'd2, 18'h3FFF8, 24'hFF0000, 24'h0000FF, 1'b0, NPIX, 2);
        chk_complete();
        chk("wrap_8th_addr", 64'(cap_addr[7]), 64'h3FFFF);
        chk("wrap_9th_addr", 64'(cap_addr[8]), 64'h00000);

        // Gradient with random stalls.
        run_frame(2'd3, 18'h00000, 24'h0, 24'h0, 1'b1, NPIX, 3);
        chk_complete();

        // Spot values from the captured frames.
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("vec%0d_pixel", i),
                64'(cap_data[vecs[i].m][vecs[i].y * IMG_W + vecs[i].x]), 64'(vecs[i].exp));
        end

        // Reset mid-frame abandons the frame; nothing resumes afterwards.
        run_frame(2'd0, 18'h00100, 24'h0, 24'h0, 1'b0, 500, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_wr_en", 64'(wr_en), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("no_resume", 64'(wr_en), 64'd0);
        end
        run_frame(2'd0, 18'h00100, 24'h0, 24'h0, 1'b0, NPIX, 0);
        chk_complete();
        chk("restart_first_addr", 64'(cap_addr[0]), 64'h100);
        chk("restart_first_data", 64'(cap_data[0][0]), 64'h00C0C0C0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
